// File: rtl/booth_divider_seq.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, with signs fixed up once the magnitudes are done.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              request, sampled only while idle
//   dividend, divisor  N-bit signed operands, captured on the accepting edge
//   quotient           N-bit signed quotient (truncated toward zero), registered
//   remainder          N-bit signed remainder (sign of dividend), registered
//   busy               high from the accepting edge until the done state is left
//   done               one-cycle pulse once quotient/remainder are valid
//   div_by_zero        set with the result when the divisor was zero
module booth_divider_seq #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned AW = N + 1;
    localparam int unsigned SW = N + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic           sign_q_q, sign_q_d;
    logic           sign_r_q, sign_r_d;
    logic           zero_q, zero_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    // Shifted partial remainder carries one spare bit so the trial compare is exact
    logic [SW-1:0]  a_sh;
    logic [SW-1:0]  m_ext;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        dvd_d       = dvd_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        zero_d      = zero_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        a_sh        = {a_q, q_q[N-1]};
        m_ext       = {2'b00, m_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Magnitude of -2^(N-1) wraps to 2^(N-1), still valid as unsigned
                    q_d      = dividend[N-1] ? -dividend : dividend;
                    m_d      = divisor[N-1]  ? -divisor  : divisor;
                    a_d      = '0;
                    dvd_d    = dividend;
                    sign_q_d = dividend[N-1] ^ divisor[N-1];
                    sign_r_d = dividend[N-1];
                    zero_d   = (divisor == '0);
                    count_d  = CW'(N);
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (a_sh >= m_ext) begin
                    a_d = AW'(a_sh - m_ext);
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    a_d = a_sh[AW-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = sign_q_q ? -q_q : q_q;
                    remainder_d = sign_r_q ? -a_q[N-1:0] : a_q[N-1:0];
                    dbz_d       = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            dvd_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            zero_q      <= 1'b0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            dvd_q       <= dvd_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            zero_q      <= zero_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Bench for booth_divider_seq (N=16): directed corner cases then random
// operand pairs, each result compared with signed integer / and % arithmetic.
module tb_booth_divider_seq;

    localparam int unsigned N = 16;
    localparam int LATENCY = 18;
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks;
    int failures;
    int done_cnt;
    int exp_done;

    booth_divider_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic, truncated to N bits (wraps -2^15/-1)
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] eq, output logic [N-1:0] er, output logic ez);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = 16'(sa / sb);
            er = 16'(sa % sb);
            ez = 1'b0;
        end
    endtask

    // One operation; glitch>0 pulses start with other operands at that cycle of the op
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input string tag, input int glitch);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        int           cyc;
        model(a, b, eq, er, ez);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (glitch > 0 && cyc == glitch) begin
                start    = 1'b1;
                dividend = 16'd999;
                divisor  = 16'd3;
            end
        end
        start = 1'b0;
        exp_done++;
        chk({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
        chk({tag, "_quot"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        exp_done = 0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quot", 32'(quotient), 32'd0);
        chk("reset_rem", 32'(remainder), 32'd0);
        chk("reset_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd100, 16'd7, "t100_7", 0);
        run_op(-16'sd100, 16'd7, "tn100_7", 0);
        run_op(16'd100, -16'sd7, "t100_n7", 0);
        run_op(-16'sd100, -16'sd7, "tn100_n7", 0);
        run_op(16'd0, 16'd5, "t0_5", 0);
        run_op(16'h8000, 16'hFFFF, "tmin_n1", 0);
        run_op(16'h8000, 16'd1, "tmin_1", 0);
        run_op(16'd7, 16'd100, "t7_100", 0);
        run_op(16'd1234, 16'd0, "t1234_0", 0);
        run_op(16'd9, 16'd3, "t9_3", 0);
        run_op(16'd12345, 16'd11, "tglitch", 5);
        // Done pulse is one cycle wide
        @(posedge clk);
        #1;
        chk("done_single", 32'(done), 32'd0);
        run_op(16'hFFFF, 16'h8000, "tn1_min", 0);

        // Asynchronous reset mid-run
        @(negedge clk);
        dividend = 16'd1234;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd50, 16'd5, "t50_5", 0);

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) rb = -rb;
            if ($urandom_range(0, 15) == 0) ra = 16'h8000;
            run_op(ra, rb, "rand", 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
